// File: rtl/load_store_sequencer.sv
// rtl/load_store_sequencer.sv - byte-addressed sized load/store to word-addressed four-phase memory sequencer
module load_store_sequencer #(
  parameter int SIZE = 32,
  localparam int SIZE_BYTES = SIZE / 8,
  localparam int OFFSET_SIZE = $clog2(SIZE_BYTES),
  localparam int MEMORY_WORD_ADDRESS_SIZE = SIZE - OFFSET_SIZE
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                request_valid,
  output logic                                request_ready,
  input  logic                                request_operation,
  input  logic [SIZE-1:0]                     request_address,
  input  logic [1:0]                          request_width,
  input  logic                                request_signed,
  input  logic [SIZE-1:0]                     request_data,
  output logic                                response_valid,
  output logic [SIZE-1:0]                     response_data,
  output logic                                memory_enable,
  output logic                                memory_operation,
  input  logic                                memory_ready,
  output logic [SIZE_BYTES-1:0]               memory_byte_mask,
  output logic [MEMORY_WORD_ADDRESS_SIZE-1:0] memory_word_address,
  input  logic [SIZE-1:0]                     memory_data_in,
  output logic [SIZE-1:0]                     memory_data_out
);

  typedef enum logic [2:0] {
    IDLE,
    FIRST_REQ,
    FIRST_RELEASE,
    SECOND_REQ,
    SECOND_RELEASE
  } state_t;

  state_t state;

  logic                                operation_q;
  logic                                signed_q;
  logic                                split_q;
  logic [OFFSET_SIZE-1:0]              offset_q;
  logic [SIZE-1:0]                     data_mask_q;
  logic [MEMORY_WORD_ADDRESS_SIZE-1:0] word1_q;
  logic [SIZE_BYTES-1:0]               mask_high_q;
  logic [SIZE-1:0]                     data_high_q;
  logic [SIZE-1:0]                     buffer0;
  logic [SIZE-1:0]                     buffer1;

  logic [1:0]                          width_clamped;
  logic [OFFSET_SIZE:0]                bytes;
  logic [OFFSET_SIZE-1:0]              offset;
  logic [MEMORY_WORD_ADDRESS_SIZE-1:0] word0;
  logic [SIZE_BYTES-1:0]               lanes;
  logic [SIZE-1:0]                     data_mask;
  logic [2*SIZE-1:0]                   wide_data;
  logic [2*SIZE_BYTES-1:0]             wide_mask;
  logic                                split;

  logic [2*SIZE-1:0]                   assembled;
  logic [SIZE-1:0]                     truncated;
  logic [SIZE-1:0]                     sign_select;
  logic [SIZE-1:0]                     read_result;

  assign request_ready = (state == IDLE) && !reset;

  // Alignment of the incoming request; a two-word window lets one shift cover the split case.
  always_comb begin
    width_clamped = request_width;
    if (request_width > 2'(OFFSET_SIZE)) width_clamped = 2'(OFFSET_SIZE);
    bytes = (OFFSET_SIZE + 1)'(1) << width_clamped;
    offset = request_address[OFFSET_SIZE-1:0];
    word0 = request_address[SIZE-1:OFFSET_SIZE];
    lanes = ~({SIZE_BYTES{1'b1}} << bytes);
    for (int i = 0; i < SIZE; i++) data_mask[i] = lanes[i/8];
    wide_data = {{SIZE{1'b0}}, request_data & data_mask} << {offset, 3'b000};
    wide_mask = {{SIZE_BYTES{1'b0}}, lanes} << offset;
    split = ({1'b0, offset} + bytes) > (OFFSET_SIZE + 1)'(SIZE_BYTES);
  end

  // The sign bit is the top set bit of the data mask.
  always_comb begin
    assembled = {(split_q ? buffer1 : {SIZE{1'b0}}), buffer0} >> {offset_q, 3'b000};
    truncated = assembled[SIZE-1:0] & data_mask_q;
    sign_select = data_mask_q & ~(data_mask_q >> 1);
    read_result = truncated;
    if (signed_q && |(truncated & sign_select)) read_result = truncated | ~data_mask_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= IDLE;
      memory_enable       <= 1'b0;
      memory_operation    <= 1'b0;
      memory_byte_mask    <= '0;
      memory_word_address <= '0;
      memory_data_out     <= '0;
      response_valid      <= 1'b0;
      response_data       <= '0;
      operation_q         <= 1'b0;
      signed_q            <= 1'b0;
      split_q             <= 1'b0;
      offset_q            <= '0;
      data_mask_q         <= '0;
      word1_q             <= '0;
      mask_high_q         <= '0;
      data_high_q         <= '0;
      buffer0             <= '0;
      buffer1             <= '0;
    end else begin
      response_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (request_valid) begin
            operation_q         <= request_operation;
            signed_q            <= request_signed;
            split_q             <= split;
            offset_q            <= offset;
            data_mask_q         <= data_mask;
            word1_q             <= word0 + MEMORY_WORD_ADDRESS_SIZE'(1);
            mask_high_q         <= wide_mask[2*SIZE_BYTES-1:SIZE_BYTES];
            data_high_q         <= request_operation ? wide_data[2*SIZE-1:SIZE] : '0;
            memory_enable       <= 1'b1;
            memory_operation    <= request_operation;
            memory_byte_mask    <= wide_mask[SIZE_BYTES-1:0];
            memory_word_address <= word0;
            memory_data_out     <= request_operation ? wide_data[SIZE-1:0] : '0;
            state               <= FIRST_REQ;
          end
        end
        FIRST_REQ: begin
          if (memory_ready) begin
            buffer0       <= memory_data_in;
            memory_enable <= 1'b0;
            state         <= FIRST_RELEASE;
          end
        end
        FIRST_RELEASE: begin
          if (!memory_ready) begin
            if (split_q) begin
              memory_enable       <= 1'b1;
              memory_byte_mask    <= mask_high_q;
              memory_word_address <= word1_q;
              memory_data_out     <= data_high_q;
              state               <= SECOND_REQ;
            end else begin
              response_valid <= 1'b1;
              response_data  <= operation_q ? '0 : read_result;
              state          <= IDLE;
            end
          end
        end
        SECOND_REQ: begin
          if (memory_ready) begin
            buffer1       <= memory_data_in;
            memory_enable <= 1'b0;
            state         <= SECOND_RELEASE;
          end
        end
        SECOND_RELEASE: begin
          if (!memory_ready) begin
            response_valid <= 1'b1;
            response_data  <= operation_q ? '0 : read_result;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_sequencer.sv
// tb/tb_load_store_sequencer.sv - directed self-checking bench for load_store_sequencer
module tb_load_store_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        request_valid = 1'b0;
  logic        request_ready;
  logic        request_operation = 1'b0;
  logic [31:0] request_address = '0;
  logic [1:0]  request_width = '0;
  logic        request_signed = 1'b0;
  logic [31:0] request_data = '0;
  logic        response_valid;
  logic [31:0] response_data;
  logic        memory_enable;
  logic        memory_operation;
  logic        memory_ready = 1'b0;
  logic [3:0]  memory_byte_mask;
  logic [29:0] memory_word_address;
  logic [31:0] memory_data_in = '0;
  logic [31:0] memory_data_out;

  int checks = 0;
  int failures = 0;

  logic [31:0] rdata [8];
  logic [29:0] acc_addr [8];
  logic [3:0]  acc_mask [8];
  logic [31:0] acc_data [8];
  logic        acc_op [8];
  int          n_acc = 0;
  bit          mem_hold = 1'b0;

  logic [31:0] got_resp;
  bit          got_seen;
  bit          enable_n1;
  bit          ready_at_resp;
  bit          valid_after;

  load_store_sequencer #(.SIZE(32)) dut (
    .clock(clock),
    .reset(reset),
    .request_valid(request_valid),
    .request_ready(request_ready),
    .request_operation(request_operation),
    .request_address(request_address),
    .request_width(request_width),
    .request_signed(request_signed),
    .request_data(request_data),
    .response_valid(response_valid),
    .response_data(response_data),
    .memory_enable(memory_enable),
    .memory_operation(memory_operation),
    .memory_ready(memory_ready),
    .memory_byte_mask(memory_byte_mask),
    .memory_word_address(memory_word_address),
    .memory_data_in(memory_data_in),
    .memory_data_out(memory_data_out)
  );

  always #5 clock = ~clock;

  // Memory arbiter model: records each access, answers one cycle later, releases after enable drops.
  initial begin
    forever begin
      @(posedge clock); #1;
      if (memory_enable && !memory_ready && !mem_hold) begin
        if (n_acc < 8) begin
          acc_addr[n_acc] = memory_word_address;
          acc_mask[n_acc] = memory_byte_mask;
          acc_data[n_acc] = memory_data_out;
          acc_op[n_acc]   = memory_operation;
        end
        @(posedge clock); #1;
        memory_data_in = (n_acc < 8) ? rdata[n_acc] : 32'h0;
        memory_ready = 1'b1;
        n_acc++;
        for (int k = 0; k < 50 && memory_enable; k++) begin
          @(posedge clock); #1;
        end
        memory_ready = 1'b0;
        memory_data_in = '0;
      end
    end
  end

  initial begin
    bit prev_en;
    prev_en = 1'b0;
    forever begin
      @(negedge clock);
      if (memory_enable && !prev_en) begin
        checks++;
        if (memory_ready) begin
          failures++;
          $display("FAIL four_phase enable rose with ready=%b required 0", memory_ready);
        end
      end
      prev_en = memory_enable;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic op, input logic [31:0] addr, input logic [1:0] width,
                       input logic sgn, input logic [31:0] data);
    int k;
    n_acc = 0;
    got_seen = 1'b0;
    got_resp = '0;
    ready_at_resp = 1'b0;
    valid_after = 1'b1;
    k = 0;
    while (!request_ready && k < 50) begin
      @(posedge clock); #1;
      k++;
    end
    request_valid = 1'b1;
    request_operation = op;
    request_address = addr;
    request_width = width;
    request_signed = sgn;
    request_data = data;
    @(posedge clock); #1;
    request_valid = 1'b0;
    enable_n1 = memory_enable;
    for (k = 0; k < 100; k++) begin
      if (response_valid) begin
        got_seen = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    if (got_seen) begin
      got_resp = response_data;
      ready_at_resp = request_ready;
      @(posedge clock); #1;
      valid_after = response_valid;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++; if (request_ready !== 1'b0) begin failures++; $display("FAIL rst_ready_in_reset got=%b exp=0", request_ready); end
    reset = 1'b0;
    #1;
    checks++; if (request_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", request_ready); end
    checks++; if (memory_enable !== 1'b0) begin failures++; $display("FAIL rst_enable got=%b exp=0", memory_enable); end
    checks++; if (memory_byte_mask !== 4'h0) begin failures++; $display("FAIL rst_mask got=%h exp=0", memory_byte_mask); end
    checks++; if (memory_word_address !== 30'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", memory_word_address); end
    checks++; if (memory_data_out !== 32'h0) begin failures++; $display("FAIL rst_data_out got=%h exp=0", memory_data_out); end
    checks++; if (response_valid !== 1'b0 || response_data !== 32'h0) begin failures++; $display("FAIL rst_response got=%b/%h exp=0/0", response_valid, response_data); end
  endtask

  task automatic test_aligned_write();
    issue(1'b1, 32'h100, 2'd2, 1'b0, 32'hDEADBEEF);
    checks++; if (enable_n1 !== 1'b1) begin failures++; $display("FAIL aw_enable_latency got=%b exp=1", enable_n1); end
    checks++; if (got_seen !== 1'b1) begin failures++; $display("FAIL aw_response_seen got=%b exp=1", got_seen); end
    checks++; if (n_acc !== 1) begin failures++; $display("FAIL aw_accesses got=%0d exp=1", n_acc); end
    checks++; if (acc_addr[0] !== 30'h40) begin failures++; $display("FAIL aw_addr got=%h exp=40", acc_addr[0]); end
    checks++; if (acc_mask[0] !== 4'b1111) begin failures++; $display("FAIL aw_mask got=%b exp=1111", acc_mask[0]); end
    checks++; if (acc_data[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL aw_data got=%h exp=deadbeef", acc_data[0]); end
    checks++; if (acc_op[0] !== 1'b1) begin failures++; $display("FAIL aw_op got=%b exp=1", acc_op[0]); end
    checks++; if (got_resp !== 32'h0) begin failures++; $display("FAIL aw_resp got=%h exp=0", got_resp); end
    checks++; if (ready_at_resp !== 1'b1) begin failures++; $display("FAIL aw_ready_with_resp got=%b exp=1", ready_at_resp); end
    checks++; if (valid_after !== 1'b0) begin failures++; $display("FAIL aw_pulse_width got=%b exp=0", valid_after); end
  endtask

  task automatic test_byte_read();
    rdata[0] = 32'h80123456;
    issue(1'b0, 32'h103, 2'd0, 1'b1, 32'hFFFFFFFF);
    checks++; if (acc_mask[0] !== 4'b1000) begin failures++; $display("FAIL br_mask got=%b exp=1000", acc_mask[0]); end
    checks++; if (acc_data[0] !== 32'h0 || acc_op[0] !== 1'b0) begin failures++; $display("FAIL br_read_out got=%h/%b exp=0/0", acc_data[0], acc_op[0]); end
    checks++; if (got_resp !== 32'hFFFFFF80) begin failures++; $display("FAIL br_signed got=%h exp=ffffff80", got_resp); end
    issue(1'b0, 32'h103, 2'd0, 1'b0, 32'h0);
    checks++; if (got_resp !== 32'h00000080) begin failures++; $display("FAIL br_unsigned got=%h exp=00000080", got_resp); end
    checks++; if (n_acc !== 1) begin failures++; $display("FAIL br_accesses got=%0d exp=1", n_acc); end
  endtask

  task automatic test_misaligned_write();
    issue(1'b1, 32'h102, 2'd2, 1'b0, 32'h11223344);
    checks++; if (n_acc !== 2) begin failures++; $display("FAIL mw_accesses got=%0d exp=2", n_acc); end
    checks++; if (acc_addr[0] !== 30'h40 || acc_mask[0] !== 4'b1100) begin failures++; $display("FAIL mw_first got=%h/%b exp=40/1100", acc_addr[0], acc_mask[0]); end
    checks++; if (acc_data[0] !== 32'h33440000) begin failures++; $display("FAIL mw_first_data got=%h exp=33440000", acc_data[0]); end
    checks++; if (acc_addr[1] !== 30'h41 || acc_mask[1] !== 4'b0011) begin failures++; $display("FAIL mw_second got=%h/%b exp=41/0011", acc_addr[1], acc_mask[1]); end
    checks++; if (acc_data[1] !== 32'h00001122) begin failures++; $display("FAIL mw_second_data got=%h exp=00001122", acc_data[1]); end
    checks++; if (got_resp !== 32'h0 || got_seen !== 1'b1) begin failures++; $display("FAIL mw_resp got=%h/%b exp=0/1", got_resp, got_seen); end
  endtask

  task automatic test_misaligned_half_read();
    rdata[0] = 32'hAB000000;
    rdata[1] = 32'h000000CD;
    issue(1'b0, 32'h107, 2'd1, 1'b1, 32'h0);
    checks++; if (n_acc !== 2) begin failures++; $display("FAIL mh_accesses got=%0d exp=2", n_acc); end
    checks++; if (acc_mask[0] !== 4'b1000 || acc_mask[1] !== 4'b0001) begin failures++; $display("FAIL mh_masks got=%b/%b exp=1000/0001", acc_mask[0], acc_mask[1]); end
    checks++; if (acc_addr[0] !== 30'h41 || acc_addr[1] !== 30'h42) begin failures++; $display("FAIL mh_addrs got=%h/%h exp=41/42", acc_addr[0], acc_addr[1]); end
    checks++; if (got_resp !== 32'hFFFFCDAB) begin failures++; $display("FAIL mh_resp got=%h exp=ffffcdab", got_resp); end
  endtask

  task automatic test_wrap_read();
    rdata[0] = 32'h11223344;
    rdata[1] = 32'h55667788;
    issue(1'b0, 32'hFFFFFFFE, 2'd2, 1'b0, 32'h0);
    checks++; if (acc_addr[0] !== 30'h3FFFFFFF || acc_addr[1] !== 30'h0) begin failures++; $display("FAIL wr_addrs got=%h/%h exp=3fffffff/0", acc_addr[0], acc_addr[1]); end
    checks++; if (acc_mask[0] !== 4'b1100 || acc_mask[1] !== 4'b0011) begin failures++; $display("FAIL wr_masks got=%b/%b exp=1100/0011", acc_mask[0], acc_mask[1]); end
    checks++; if (got_resp !== 32'h77881122) begin failures++; $display("FAIL wr_resp got=%h exp=77881122", got_resp); end
  endtask

  task automatic test_width_clamp();
    rdata[0] = 32'hCAFEF00D;
    issue(1'b0, 32'h200, 2'd3, 1'b1, 32'h0);
    checks++; if (n_acc !== 1 || acc_mask[0] !== 4'b1111) begin failures++; $display("FAIL wc_access got=%0d/%b exp=1/1111", n_acc, acc_mask[0]); end
    checks++; if (acc_addr[0] !== 30'h80) begin failures++; $display("FAIL wc_addr got=%h exp=80", acc_addr[0]); end
    checks++; if (got_resp !== 32'hCAFEF00D) begin failures++; $display("FAIL wc_resp got=%h exp=cafef00d", got_resp); end
  endtask

  task automatic test_reset_mid();
    int seen;
    mem_hold = 1'b1;
    request_valid = 1'b1;
    request_operation = 1'b1;
    request_address = 32'h100;
    request_width = 2'd2;
    request_signed = 1'b0;
    request_data = 32'h12345678;
    @(posedge clock); #1;
    request_valid = 1'b0;
    checks++; if (memory_enable !== 1'b1 || memory_data_out !== 32'h12345678) begin failures++; $display("FAIL rm_started got=%b/%h exp=1/12345678", memory_enable, memory_data_out); end
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    checks++; if (memory_enable !== 1'b0) begin failures++; $display("FAIL rm_enable got=%b exp=0", memory_enable); end
    checks++; if (memory_byte_mask !== 4'h0 || memory_word_address !== 30'h0) begin failures++; $display("FAIL rm_mask_addr got=%b/%h exp=0/0", memory_byte_mask, memory_word_address); end
    checks++; if (memory_data_out !== 32'h0 || memory_operation !== 1'b0) begin failures++; $display("FAIL rm_data_op got=%h/%b exp=0/0", memory_data_out, memory_operation); end
    checks++; if (response_data !== 32'h0) begin failures++; $display("FAIL rm_resp_data got=%h exp=0", response_data); end
    checks++; if (request_ready !== 1'b1) begin failures++; $display("FAIL rm_ready got=%b exp=1", request_ready); end
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (response_valid) seen++;
      @(posedge clock); #1;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL rm_no_response got=%0d exp=0", seen); end
    mem_hold = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rdata[i] = '0;
    test_reset();
    test_aligned_write();
    test_byte_read();
    test_misaligned_write();
    test_misaligned_half_read();
    test_wrap_read();
    test_width_clamp();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
